// File: rtl/uart_ctrl_pkg.sv
// Shared constants for the UART transmit-side control blocks.
package uart_ctrl_pkg;

  localparam int unsigned BYTE_W             = 8;
  localparam int unsigned IDX_W              = 3;
  localparam int unsigned TMO_W              = 10;
  localparam int unsigned GAP_W              = 4;
  localparam int unsigned DEF_GAP_CYCLES     = 2;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 1023;

  // Sequencer state encoding (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE      = 3'b000;
  localparam logic [2:0] ST_ISSUE     = 3'b001;
  localparam logic [2:0] ST_WAIT_BUSY = 3'b010;
  localparam logic [2:0] ST_WAIT_DONE = 3'b011;
  localparam logic [2:0] ST_GAP       = 3'b100;

  typedef logic [BYTE_W-1:0] byte_t;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester / transmitter / status bundle of the transmit arbiter.
interface uart_tx_arbiter_if
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]        req_valid;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ready;
  logic                      xmit;
  logic [BYTE_W-1:0]         xmit_data;
  logic                      xmit_done;
  logic                      busy;
  logic [IDX_W-1:0]          grant_id;
  logic                      err_timeout;
  logic                      err_clr;

  // Environment side: byte producers, transmitter and status consumer
  modport master (
    output req_valid, req_data, xmit_done, err_clr,
    input  req_ready, xmit, xmit_data, busy, grant_id, err_timeout
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data, xmit_done, err_clr,
    output req_ready, xmit, xmit_data, busy, grant_id, err_timeout
  );

endinterface

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first valid index at or after the pointer.
module rr_pick #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = 3
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  localparam int unsigned SEL_W = (N > 1) ? $clog2(N) : 1;

  int unsigned      pos;
  logic [SEL_W-1:0] sel;

  // Scan N positions starting at the pointer, wrapping modulo N
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    sel     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = (32'(ptr_i) + k) % N;
      sel = SEL_W'(pos);
      if (!any_o && valid_i[sel]) begin
        any_o        = 1'b1;
        grant_o[sel] = 1'b1;
        idx_o        = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter and frame sequencer sharing one UART transmitter.
module uart_tx_arbiter
  import uart_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic              sys_clk,
  input logic              sys_rst,
  uart_tx_arbiter_if.slave bus
);

  localparam int unsigned    SEL_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [GAP_W-1:0] GAP_LOAD  = GAP_W'(GAP_CYCLES);

  logic [2:0]         state_q, state_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d, tmo_inc;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic               xmit_q, xmit_d;
  logic [BYTE_W-1:0]  xmit_data_q, xmit_data_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic [NUM_REQ-1:0] req_ready_c;

  logic [NUM_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0]   pick_idx;
  logic               pick_any;
  byte_t              req_bytes [NUM_REQ];
  byte_t              pick_byte;

  // Split the flat request bus into per-requester bytes
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_bytes
    assign req_bytes[i] = bus.req_data[i*BYTE_W +: BYTE_W];
  end

  assign pick_byte = req_bytes[pick_idx[SEL_W-1:0]];

  rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .valid_i (bus.req_valid),
    .ptr_i   (rr_q),
    .grant_o (pick_onehot),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Next-state, accept and counter logic
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    tmo_d       = tmo_q;
    gap_d       = gap_q;
    xmit_d      = 1'b0;
    xmit_data_d = xmit_data_q;
    grant_d     = grant_q;
    err_d       = err_q;
    req_ready_c = '0;
    tmo_inc     = tmo_q + TMO_W'(1);

    if (bus.err_clr) err_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && bus.xmit_done) begin
          req_ready_c = pick_onehot;
          xmit_data_d = pick_byte;
          grant_d     = pick_idx;
          rr_d        = (32'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + IDX_W'(1);
          xmit_d      = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_d   = '0;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY, ST_WAIT_DONE: begin
        tmo_d = tmo_inc;
        if (tmo_inc == TMO_LIMIT) begin
          // Abort: the byte is dropped, a set here beats a same-cycle clear
          err_d   = 1'b1;
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end else if (state_q == ST_WAIT_BUSY && !bus.xmit_done) begin
          state_d = ST_WAIT_DONE;
        end else if (state_q == ST_WAIT_DONE && bus.xmit_done) begin
          gap_d   = GAP_LOAD;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_q <= GAP_W'(1)) begin
          gap_d   = '0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and registered outputs, synchronous reset
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q     <= ST_IDLE;
      rr_q        <= '0;
      tmo_q       <= '0;
      gap_q       <= '0;
      xmit_q      <= 1'b0;
      xmit_data_q <= '0;
      grant_q     <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      tmo_q       <= tmo_d;
      gap_q       <= gap_d;
      xmit_q      <= xmit_d;
      xmit_data_q <= xmit_data_d;
      grant_q     <= grant_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready   = sys_rst ? '0 : req_ready_c;
  assign bus.xmit        = xmit_q;
  assign bus.xmit_data   = xmit_data_q;
  assign bus.busy        = busy_q;
  assign bus.grant_id    = grant_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter with a transaction-timing reference model.
module tb_uart_tx_arbiter;
  import uart_ctrl_pkg::*;

  localparam int unsigned NR      = 4;
  localparam int unsigned GAP     = 2;
  localparam int unsigned TMO     = 1023;
  localparam int          GAP_EFF = (GAP == 0) ? 1 : int'(GAP);

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ        (NR),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Reference model state
  int             c, ptr, acc_cyc, lo_at, hi_at, ret_at, idle_at, fire_at, frames, g;
  bit             have_acc, stuck, collide, err_exp, acc_now, done_now, clr_now;
  bit             has [NR];
  logic [7:0]     pend [NR];
  logic [7:0]     exp_byte;
  int             exp_gid;
  logic [NR-1:0]  vld, exp_rdy;
  logic [8*NR-1:0] dat;

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.xmit_done = 1'b1;
    bus.err_clr   = 1'b0;

    // Reset state, with a request presented while in reset
    next_cycle();
    next_cycle();
    bus.req_valid = '1;
    settle();
    check_eq("rst_req_ready", 32'(bus.req_ready), 32'(0));
    check_eq("rst_busy", 32'(bus.busy), 32'(0));
    check_eq("rst_xmit", 32'(bus.xmit), 32'(0));
    check_eq("rst_xmit_data", 32'(bus.xmit_data), 32'(0));
    check_eq("rst_grant_id", 32'(bus.grant_id), 32'(0));
    check_eq("rst_err", 32'(bus.err_timeout), 32'(0));

    // Single request from requester 2
    next_cycle();
    rst            = 1'b0;
    bus.req_valid  = 4'b0100;
    dat            = '0;
    dat[23:16]     = 8'hA5;
    bus.req_data   = dat;
    settle();
    check_eq("single_ready", 32'(bus.req_ready), 32'(4'b0100));
    next_cycle();
    bus.req_valid = '0;
    settle();
    check_eq("single_xmit", 32'(bus.xmit), 32'(1));
    check_eq("single_xmit_data", 32'(bus.xmit_data), 32'(8'hA5));
    check_eq("single_grant_id", 32'(bus.grant_id), 32'(2));
    check_eq("single_busy", 32'(bus.busy), 32'(1));
    next_cycle();
    bus.xmit_done = 1'b0;
    settle();
    check_eq("single_xmit_pulse", 32'(bus.xmit), 32'(0));
    next_cycle();
    settle();
    check_eq("wait_done_busy", 32'(bus.busy), 32'(1));

    // Reset in the middle of the frame
    next_cycle();
    rst = 1'b1;
    settle();
    next_cycle();
    rst           = 1'b0;
    bus.xmit_done = 1'b1;
    settle();
    check_eq("midrst_busy", 32'(bus.busy), 32'(0));
    check_eq("midrst_xmit", 32'(bus.xmit), 32'(0));
    check_eq("midrst_err", 32'(bus.err_timeout), 32'(0));
    check_eq("midrst_grant_id", 32'(bus.grant_id), 32'(0));
    check_eq("midrst_xmit_data", 32'(bus.xmit_data), 32'(0));

    // Randomized traffic against the timing model
    ptr      = 0;
    have_acc = 1'b0;
    idle_at  = 0;
    err_exp  = 1'b0;
    frames   = 0;
    c        = 0;
    stuck    = 1'b0;
    collide  = 1'b0;
    acc_cyc  = 0;
    lo_at    = 0;
    hi_at    = 0;
    ret_at   = 0;
    fire_at  = 0;
    exp_byte = '0;
    exp_gid  = 0;
    for (int i = 0; i < int'(NR); i++) begin
      has[i]  = 1'b0;
      pend[i] = '0;
    end

    while (frames < 40 && c < 20000) begin
      next_cycle();
      for (int i = 0; i < int'(NR); i++) begin
        if (!has[i] && $urandom_range(0, 3) == 0) begin
          has[i]  = 1'b1;
          pend[i] = 8'($urandom);
        end
        vld[i]          = has[i] && ($urandom_range(0, 5) != 0);
        dat[i*8 +: 8]   = has[i] ? pend[i] : 8'($urandom);
      end
      // Transmitter: idle-high, drops low after a short delay, returns high when the frame ends
      if (have_acc && c > acc_cyc && c <= ret_at)
        done_now = stuck ? 1'b1 : !(c >= lo_at && c < hi_at);
      else
        done_now = ($urandom_range(0, 5) != 0);
      if (have_acc && stuck && collide && c == fire_at) clr_now = 1'b1;
      else                                              clr_now = ($urandom_range(0, 15) == 0);
      bus.req_valid = vld;
      bus.req_data  = dat;
      bus.xmit_done = done_now;
      bus.err_clr   = clr_now;
      settle();

      exp_rdy = '0;
      acc_now = 1'b0;
      g       = 0;
      if ((!have_acc || c >= idle_at) && done_now) begin
        for (int k = 0; k < int'(NR); k++) begin
          if (!acc_now && vld[(ptr + k) % int'(NR)]) begin
            acc_now = 1'b1;
            g       = (ptr + k) % int'(NR);
          end
        end
      end
      if (acc_now) exp_rdy[g] = 1'b1;

      check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
      check_eq("xmit", 32'(bus.xmit), 32'(have_acc && c == acc_cyc + 1));
      check_eq("busy", 32'(bus.busy), 32'(have_acc && c > acc_cyc && c < idle_at));
      check_eq("err_timeout", 32'(bus.err_timeout), 32'(err_exp));
      if (have_acc && c == acc_cyc + 1) begin
        check_eq("xmit_data", 32'(bus.xmit_data), 32'(exp_byte));
        check_eq("grant_id", 32'(bus.grant_id), 32'(exp_gid));
      end

      if (have_acc && stuck && c == fire_at) err_exp = 1'b1;
      else if (clr_now)                      err_exp = 1'b0;

      if (acc_now) begin
        has[g]   = 1'b0;
        exp_byte = pend[g];
        exp_gid  = g;
        ptr      = (g + 1) % int'(NR);
        have_acc = 1'b1;
        acc_cyc  = c;
        frames++;
        stuck    = (frames == 3 || frames == 17);
        collide  = (frames == 3);
        lo_at    = c + 2 + int'($urandom_range(0, 3));
        hi_at    = lo_at + int'($urandom_range(1, 20));
        // Counter runs from the first WAIT_BUSY cycle (accept+2) and aborts on its TMO-th cycle
        fire_at  = c + 1 + int'(TMO);
        ret_at   = stuck ? fire_at : hi_at;
        idle_at  = ret_at + GAP_EFF + 1;
      end
      c++;
    end

    check_eq("frames_done", 32'(frames >= 40), 32'(1));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
